// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer
// Sequences the shared iterative multiplier and divider of the multicycle MIPS core.
// It turns one-cycle start requests into load/step strobes, counts iterations,
// commits the result to HI/LO and reports completion or divide-by-zero to control.
module muldiv_sequencer #(
  parameter int ITER_MUL = 32,
  parameter int ITER_DIV = 32,
  parameter int CNT_W    = 6
) (
  input  logic clock,
  input  logic Reset,
  input  logic CtoM,
  input  logic CtoD,
  input  logic divisor_zero,
  output logic mul_load,
  output logic mul_step,
  output logic div_load,
  output logic div_step,
  output logic divOrMul,
  output logic writeH,
  output logic writeL,
  output logic busy,
  output logic MtoC,
  output logic DtoC,
  output logic DivZero
);

  typedef enum logic [2:0] {
    IDLE,
    MLOAD,
    MRUN,
    DLOAD,
    DRUN,
    DZERO,
    WRHL
  } state_t;

  // Final counter value of each run phase; the run lasts ITER cycles starting from 0.
  localparam logic [CNT_W-1:0] MulLast = CNT_W'(ITER_MUL - 1);
  localparam logic [CNT_W-1:0] DivLast = CNT_W'(ITER_DIV - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             divOrMul_q, divOrMul_d;

  // State, iteration counter and HI/LO source select registers.
  always_ff @(posedge clock) begin
    if (Reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      divOrMul_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      divOrMul_q <= divOrMul_d;
    end
  end

  // Next-state logic plus strobes decoded purely from the registered state.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    divOrMul_d = divOrMul_q;
    mul_load   = 1'b0;
    mul_step   = 1'b0;
    div_load   = 1'b0;
    div_step   = 1'b0;
    writeH     = 1'b0;
    writeL     = 1'b0;
    busy       = 1'b1;
    MtoC       = 1'b0;
    DtoC       = 1'b0;
    DivZero    = 1'b0;
    unique case (state_q)
      IDLE: begin
        busy = 1'b0;
        if (CtoM) begin
          state_d = MLOAD;
        end else if (CtoD) begin
          state_d = divisor_zero ? DZERO : DLOAD;
        end
      end
      MLOAD: begin
        mul_load   = 1'b1;
        cnt_d      = '0;
        divOrMul_d = 1'b0;
        state_d    = MRUN;
      end
      MRUN: begin
        mul_step = 1'b1;
        cnt_d    = cnt_q + CNT_W'(1);
        if (cnt_q == MulLast) begin
          state_d = WRHL;
        end
      end
      DLOAD: begin
        div_load   = 1'b1;
        cnt_d      = '0;
        divOrMul_d = 1'b1;
        state_d    = DRUN;
      end
      DRUN: begin
        div_step = 1'b1;
        cnt_d    = cnt_q + CNT_W'(1);
        if (cnt_q == DivLast) begin
          state_d = WRHL;
        end
      end
      DZERO: begin
        DivZero = 1'b1;
        state_d = IDLE;
      end
      WRHL: begin
        writeH  = 1'b1;
        writeL  = 1'b1;
        MtoC    = ~divOrMul_q;
        DtoC    = divOrMul_q;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign divOrMul = divOrMul_q;

endmodule
